// File: rtl/mac_array_ctrl_if.sv
// Control and SRAM/array bundle of the MAC array sequencer.
// The master side is the core FSM plus the array/SRAM; the slave side is the sequencer.
interface mac_array_ctrl_if #(
   parameter int addr_bw = 11,
   parameter int len_bw  = 11
);
   logic               start;
   logic               abort;
   logic [len_bw-1:0]  n_act;
   logic [addr_bw-1:0] w_base;
   logic [addr_bw-1:0] a_base;
   logic               mem_cen;
   logic [addr_bw-1:0] mem_addr;
   logic [1:0]         inst_w;
   logic               array_rst;
   logic               busy;
   logic               done;
   logic [2:0]         dbg_state;

   // start is a one-cycle request with no ready: it is accepted only while busy is low.
   modport master (
      output start, abort, n_act, w_base, a_base,
      input  mem_cen, mem_addr, inst_w, array_rst, busy, done, dbg_state
   );

   modport slave (
      input  start, abort, n_act, w_base, a_base,
      output mem_cen, mem_addr, inst_w, array_rst, busy, done, dbg_state
   );
endinterface

// File: rtl/mac_array_ctrl.sv
// Per-layer sequencer for the weight-stationary MAC array: clear, load weights,
// gap, stream activations, drain. All outputs are registered.
module mac_array_ctrl #(
   parameter int row     = 8,
   parameter int col     = 8,
   parameter int addr_bw = 11,
   parameter int len_bw  = 11
) (
   input logic               clk,
   input logic               reset,
   mac_array_ctrl_if.slave   io_bus
);

   localparam int DRAIN_LEN = row + col - 1;
   localparam int ACT_MAX   = (1 << len_bw) - 1;
   localparam int CNT_MAX0  = (col > DRAIN_LEN) ? col : DRAIN_LEN;
   localparam int CNT_MAX   = (CNT_MAX0 > ACT_MAX) ? CNT_MAX0 : ACT_MAX;
   localparam int CNT_BW    = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

   localparam logic [CNT_BW-1:0] LOAD_LAST  = CNT_BW'(col - 1);
   localparam logic [CNT_BW-1:0] DRAIN_LAST = CNT_BW'(DRAIN_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CLR, S_LOAD, S_GAP, S_EXEC, S_DRAIN, S_DONE
   } state_t;

   state_t             r_state;
   logic [CNT_BW-1:0]  r_cnt;
   logic [len_bw-1:0]  r_n_act;
   logic [addr_bw-1:0] r_w_base;
   logic [addr_bw-1:0] r_a_base;
   logic               r_mem_cen;
   logic [addr_bw-1:0] r_mem_addr;
   logic [1:0]         r_inst_w;
   logic               r_array_rst;
   logic               r_busy;
   logic               r_done;

   // r_cnt holds the remaining cycles minus one of the current phase.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_n_act     <= '0;
         r_w_base    <= '0;
         r_a_base    <= '0;
         r_mem_cen   <= 1'b1;
         r_mem_addr  <= '0;
         r_inst_w    <= 2'b00;
         r_array_rst <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else if (io_bus.abort && r_state != S_IDLE) begin
         r_state     <= S_IDLE;
         r_mem_cen   <= 1'b1;
         r_inst_w    <= 2'b00;
         r_array_rst <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         // Reads issued this cycle land at the array one cycle later.
         r_inst_w    <= {r_state == S_EXEC, r_state == S_LOAD};
         r_array_rst <= 1'b0;
         r_done      <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (io_bus.start) begin
                  r_n_act     <= io_bus.n_act;
                  r_w_base    <= io_bus.w_base;
                  r_a_base    <= io_bus.a_base;
                  r_array_rst <= 1'b1;
                  r_busy      <= 1'b1;
                  r_state     <= S_CLR;
               end
            end
            S_CLR: begin
               r_mem_cen  <= 1'b0;
               r_mem_addr <= r_w_base;
               r_cnt      <= LOAD_LAST;
               r_state    <= S_LOAD;
            end
            S_LOAD: begin
               if (r_cnt == '0) begin
                  r_mem_cen <= 1'b1;
                  r_cnt     <= LOAD_LAST;
                  r_state   <= S_GAP;
               end else begin
                  r_cnt      <= r_cnt - 1'b1;
                  r_mem_addr <= r_mem_addr + addr_bw'(1);
               end
            end
            S_GAP: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 1'b1;
               end else if (r_n_act == '0) begin
                  r_cnt   <= DRAIN_LAST;
                  r_state <= S_DRAIN;
               end else begin
                  r_mem_cen  <= 1'b0;
                  r_mem_addr <= r_a_base;
                  r_cnt      <= CNT_BW'(r_n_act - len_bw'(1));
                  r_state    <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (r_cnt == '0) begin
                  r_mem_cen <= 1'b1;
                  r_cnt     <= DRAIN_LAST;
                  r_state   <= S_DRAIN;
               end else begin
                  r_cnt      <= r_cnt - 1'b1;
                  r_mem_addr <= r_mem_addr + addr_bw'(1);
               end
            end
            S_DRAIN: begin
               if (r_cnt == '0) begin
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_mem_cen <= 1'b1;
               r_busy    <= 1'b0;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

   assign io_bus.mem_cen   = r_mem_cen;
   assign io_bus.mem_addr  = r_mem_addr;
   assign io_bus.inst_w    = r_inst_w;
   assign io_bus.array_rst = r_array_rst;
   assign io_bus.busy      = r_busy;
   assign io_bus.done      = r_done;
   assign io_bus.dbg_state = r_state;

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Bench for mac_array_ctrl: each run pushes its expected cycle-by-cycle output
// trace into exp_q; a monitor pops one entry per cycle and compares.
module tb_mac_array_ctrl;

   localparam int ROW = 8;
   localparam int COL = 8;
   localparam int AW  = 11;
   localparam int LW  = 11;
   localparam int W   = AW + 7;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mac_array_ctrl_if #(.addr_bw(AW), .len_bw(LW)) bus ();

   mac_array_ctrl #(.row(ROW), .col(COL), .addr_bw(AW), .len_bw(LW)) dut (
      .clk    (clk),
      .reset  (reset),
      .io_bus (bus)
   );

   // Entry layout: {chk_addr, busy, array_rst, mem_cen, mem_addr, inst_w, done}
   logic [W-1:0] exp_q[$];
   int checks   = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] mk(input logic chk, input logic busy, input logic rst,
                                       input logic cen, input logic [AW-1:0] addr,
                                       input logic [1:0] inst, input logic done);
      logic [AW-1:0] a;
      a = chk ? addr : {AW{1'b0}};
      return {chk, busy, rst, cen, a, inst, done};
   endfunction

   // Expected trace of one layer; a stop truncates it after cycle stop_at.
   task automatic push_run(input int n, input logic [AW-1:0] w, input logic [AW-1:0] a,
                           input int stop_at, input bit by_reset, output int len);
      logic [W-1:0] t[$];
      t.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, '0, 2'b00, 1'b0));
      for (int k = 0; k < COL; k++)
         t.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, w + AW'(k), (k == 0) ? 2'b00 : 2'b01, 1'b0));
      for (int j = 0; j < COL; j++)
         t.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, '0, (j == 0) ? 2'b01 : 2'b00, 1'b0));
      for (int k = 0; k < n; k++)
         t.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, a + AW'(k), (k == 0) ? 2'b00 : 2'b10, 1'b0));
      for (int j = 0; j < ROW + COL - 1; j++)
         t.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, '0, (j == 0 && n > 0) ? 2'b10 : 2'b00, 1'b0));
      t.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, '0, 2'b00, 1'b1));
      if (stop_at > 0) begin
         while (t.size() > stop_at) void'(t.pop_back());
         t.push_back(mk(by_reset, 1'b0, 1'b0, 1'b1, '0, 2'b00, 1'b0));
      end else begin
         t.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, '0, 2'b00, 1'b0));
      end
      len = t.size();
      foreach (t[i]) exp_q.push_back(t[i]);
   endtask

   // Called at a negedge; returns at the negedge of the trailing IDLE cycle.
   task automatic run_layer(input int n, input logic [AW-1:0] w, input logic [AW-1:0] a,
                            input int stop_at, input bit by_reset,
                            input int pulse_a, input int pulse_b, input bit abort_with_start);
      int len;
      bus.start  = 1'b1;
      bus.abort  = abort_with_start;
      bus.n_act  = LW'(n);
      bus.w_base = w;
      bus.a_base = a;
      push_run(n, w, a, stop_at, by_reset, len);
      for (int cyc = 1; cyc <= len; cyc++) begin
         @(negedge clk);
         bus.start  = (cyc == pulse_a) || (cyc == pulse_b);
         bus.abort  = !by_reset && stop_at > 0 && cyc == stop_at;
         reset      = by_reset && stop_at > 0 && cyc == stop_at;
         bus.n_act  = LW'($urandom_range(0, 2047));
         bus.w_base = AW'($urandom_range(0, 2047));
         bus.a_base = AW'($urandom_range(0, 2047));
      end
   endtask

   initial begin
      logic [W-1:0]  e;
      logic [W-1:0]  obs;
      logic [AW-1:0] oa;
      int mon_n;
      mon_n = 0;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            oa = e[W-1] ? bus.mem_addr : {AW{1'b0}};
            obs = {e[W-1], bus.busy, bus.array_rst, bus.mem_cen, oa, bus.inst_w, bus.done};
            check_eq($sformatf("trace%0d", mon_n), 64'(obs), 64'(e));
            mon_n++;
         end
      end
   end

   initial begin
      reset      = 1'b1;
      bus.start  = 1'b0;
      bus.abort  = 1'b0;
      bus.n_act  = '0;
      bus.w_base = '0;
      bus.a_base = '0;
      repeat (2) @(negedge clk);
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, '0, 2'b00, 1'b0));
      @(negedge clk);
      reset = 1'b0;

      run_layer(16, 11'h010, 11'h100, 0, 1'b0, 0, 0, 1'b0);
      run_layer(0,  11'h020, 11'h200, 0, 1'b0, 0, 0, 1'b0);
      run_layer(8,  11'h030, 11'h7FC, 0, 1'b0, 0, 0, 1'b0);
      run_layer(16, 11'h040, 11'h300, 21, 1'b0, 0, 0, 1'b0);
      run_layer(16, 11'h010, 11'h100, 0, 1'b0, 0, 0, 1'b0);
      run_layer(16, 11'h050, 11'h400, 0, 1'b0, 4, 40, 1'b0);
      run_layer(5,  11'h060, 11'h500, 12, 1'b1, 0, 0, 1'b0);
      run_layer(3,  11'h070, 11'h600, 0, 1'b0, 0, 0, 1'b0);
      run_layer(4,  11'h080, 11'h610, 0, 1'b0, 0, 0, 1'b1);
      for (int i = 0; i < 2; i++)
         run_layer($urandom_range(1, 20), AW'($urandom_range(0, 2047)),
                   AW'($urandom_range(0, 2047)), 0, 1'b0, 0, 0, 1'b0);

      bus.start = 1'b0;
      bus.abort = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
